sma_out: RTL and testbench
==========================

SMA_OUT -- requirements
Module: sma_out

Interface
REQ-001 Parameter CNT_W, default 16: width of the WIDTH and PERIOD registers and of the phase counter.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 address  input  2  Avalon-MM slave word address.
REQ-005 write  input  1  write strobe, one cycle per access.
REQ-006 writedata  input  32  write data.
REQ-007 readdata  output  32  registered read data.
REQ-008 out_port  output  1  registered SMA output pin.

Function
REQ-009 Register map SHALL be: 0 DATA (bit0 static level), 1 CTRL, 2 WIDTH (CNT_W bits), 3 PERIOD (CNT_W bits); unused bits read 0, writes to them ignored.
REQ-010 CTRL SHALL be: bit0 MODE (0 static, 1 pulse), bit1 START (write-only, self-clearing), bit2 REPEAT, bit3 POL (1 inverts out_port), bit4 ABORT (write-only, self-clearing), bit5 BUSY (read-only).
REQ-011 readdata SHALL update every cycle to the addressed register, one-cycle latency, no read strobe; START/ABORT read 0.
REQ-012 Pulse engine FSM states SHALL be IDLE, HIGH, LOW; BUSY = (state != IDLE).
REQ-013 out_port SHALL equal POL XOR (MODE ? (state==HIGH) : DATA[0]), registered.
REQ-014 A write with START=1, MODE=1, WIDTH!=0 in IDLE SHALL enter HIGH on that edge; out_port is active for exactly WIDTH cycles.
REQ-015 START while BUSY, with MODE=0, or with WIDTH=0 SHALL be ignored.
REQ-016 HIGH -> LOW after WIDTH cycles if REPEAT=1, else HIGH -> IDLE.
REQ-017 LOW SHALL last PERIOD-WIDTH cycles if PERIOD>WIDTH, else 1 cycle; then -> HIGH if REPEAT=1, else -> IDLE.
REQ-018 Clearing REPEAT while BUSY SHALL let the current HIGH phase complete, then -> IDLE.
REQ-019 ABORT=1 SHALL force IDLE on that edge; ABORT wins over a simultaneous START.
REQ-020 WIDTH/PERIOD writes while BUSY SHALL take effect at the next phase start; the running phase keeps its latched count.
REQ-021 Counter arithmetic SHALL be unsigned CNT_W bits, no wrap: the phase count is reloaded, never free-running.
REQ-022 A write updates its register on the same edge; the resulting out_port change is visible one cycle later.

Reset
REQ-023 On reset, SHALL clear: readdata=0, out_port=0, DATA=0, CTRL=0, WIDTH=0, PERIOD=0, state=IDLE, counter=0.
REQ-024 Reset mid-pulse SHALL abort the pulse; out_port=0 the next cycle regardless of prior POL.

Configuration
REQ-025 Macro SMA_OUT_REPEAT_EN: when defined, REPEAT, PERIOD and the LOW state SHALL exist as above.
REQ-026 Without SMA_OUT_REPEAT_EN: REPEAT reads 0, PERIOD reads 0 and ignores writes, no LOW state; every pulse is single-shot.

Structure
REQ-027 Shared package sma_pkg SHALL hold register address constants, CTRL bit indices, the FSM state type and the CNT_W default.
REQ-028 FSM and counter SHALL live in sub-module sma_pulse_gen; sma_out holds the register file, read mux and output register.

Verification
REQ-029 Reset, then write DATA=1 -> out_port=1 one cycle later; reading address 0 returns 0x00000001.
REQ-030 WIDTH=5, CTRL=0x03 -> out_port high exactly 5 cycles; BUSY=1 during the pulse, 0 after.
REQ-031 WIDTH=3, PERIOD=8, CTRL=0x07 -> repeated pulses 3 cycles high / 5 low; CTRL=0x01 mid-HIGH -> pulse completes, then IDLE.
REQ-032 CTRL=0x0B with WIDTH=4 -> out_port idles 1, low for 4 cycles, back to 1.
REQ-033 Periodic run, then write CTRL=0x13 (ABORT+START) -> IDLE next cycle, no new pulse; also assert reset mid-pulse -> out_port=0.
REQ-034 WIDTH=0 + START -> no pulse, BUSY stays 0; WIDTH=4, PERIOD=2, REPEAT -> 4 cycles high / 1 low.

Source files
------------

// File: rtl/sma_pkg.sv
// Shared definitions for the SMA output block: register map, CTRL bit positions,
// pulse-engine state type. The LOW state only exists when SMA_OUT_REPEAT_EN is defined.
package sma_pkg;

  localparam int CNT_W_DEF = 16;

  localparam logic [1:0] ADDR_DATA   = 2'd0;
  localparam logic [1:0] ADDR_CTRL   = 2'd1;
  localparam logic [1:0] ADDR_WIDTH  = 2'd2;
  localparam logic [1:0] ADDR_PERIOD = 2'd3;

  localparam int CTRL_MODE   = 0;
  localparam int CTRL_START  = 1;
  localparam int CTRL_REPEAT = 2;
  localparam int CTRL_POL    = 3;
  localparam int CTRL_ABORT  = 4;
  localparam int CTRL_BUSY   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1
`ifdef SMA_OUT_REPEAT_EN
    , ST_LOW = 2'd2
`endif
  } pulse_state_e;

endpackage

// File: rtl/sma_out_if.sv
// Avalon-MM slave bus of the SMA output block (word address, write-only strobe,
// registered read data with no read strobe).
interface sma_out_if;
  logic [1:0]  address;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (output address, write, writedata, input readdata);
  modport slave  (input address, write, writedata, output readdata);
endinterface

// File: rtl/sma_pulse_gen.sv
// Pulse engine: IDLE/HIGH(/LOW) FSM with a reloaded down-counter.
// Optional feature macro: SMA_OUT_REPEAT_EN (adds REPEAT, PERIOD and the LOW phase).
module sma_pulse_gen
  import sma_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [CNT_W-1:0] width_i,
`ifdef SMA_OUT_REPEAT_EN
  input  logic             repeat_i,
  input  logic [CNT_W-1:0] period_i,
`endif
  output pulse_state_e     state_o,
  output logic             busy_o
);

  pulse_state_e     state_q;
  logic [CNT_W-1:0] cnt_q;

`ifdef SMA_OUT_REPEAT_EN
  // LOW lasts PERIOD-WIDTH cycles, or a single cycle when PERIOD does not exceed WIDTH.
  logic [CNT_W-1:0] low_len_m1;
  assign low_len_m1 = (period_i > width_i) ? (period_i - width_i - CNT_W'(1)) : '0;
`endif

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (reset || abort_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_i && (width_i != '0)) begin
            state_q <= ST_HIGH;
            cnt_q   <= width_i - CNT_W'(1);
          end
        end
        ST_HIGH: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
`ifdef SMA_OUT_REPEAT_EN
          end else if (repeat_i) begin
            state_q <= ST_LOW;
            cnt_q   <= low_len_m1;
`endif
          end else begin
            state_q <= ST_IDLE;
          end
        end
`ifdef SMA_OUT_REPEAT_EN
        ST_LOW: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (repeat_i && (width_i != '0)) begin
            state_q <= ST_HIGH;
            cnt_q   <= width_i - CNT_W'(1);
          end else begin
            state_q <= ST_IDLE;
          end
        end
`endif
        default: begin
          state_q <= ST_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign state_o = state_q;
  assign busy_o  = (state_q != ST_IDLE);

endmodule

// File: rtl/sma_out.sv
// SMA output block: register file, registered read mux and registered output pin.
// Optional feature macro: SMA_OUT_REPEAT_EN (REPEAT bit, PERIOD register, periodic pulses).
module sma_out
  import sma_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic      clk,
  input  logic      reset,
  sma_out_if.slave  bus,
  output logic      out_port
);

  logic             data_q;
  logic             mode_q;
  logic             pol_q;
  logic [CNT_W-1:0] width_q;
`ifdef SMA_OUT_REPEAT_EN
  logic             rep_q;
  logic [CNT_W-1:0] period_q;
`endif
  logic [31:0]      rdata_d, rdata_q;
  logic             out_d, out_q;

  pulse_state_e     state;
  logic             busy;
  logic             wr_ctrl, start, abort;
  logic             unused_wdata;

  assign wr_ctrl = bus.write && (bus.address == ADDR_CTRL);
  assign start   = wr_ctrl && bus.writedata[CTRL_START] && bus.writedata[CTRL_MODE];
  assign abort   = wr_ctrl && bus.writedata[CTRL_ABORT];
  // Bits beyond each register's width are dropped on purpose.
  assign unused_wdata = ^bus.writedata;

  sma_pulse_gen #(.CNT_W(CNT_W)) u_pulse_gen (
    .clk      (clk),
    .reset    (reset),
    .start_i  (start),
    .abort_i  (abort),
    .width_i  (width_q),
`ifdef SMA_OUT_REPEAT_EN
    .repeat_i (rep_q),
    .period_i (period_q),
`endif
    .state_o  (state),
    .busy_o   (busy)
  );

  // NOTE: every signal driven here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    rdata_d = '0;
    case (bus.address)
      ADDR_DATA:  rdata_d[0] = data_q;
      ADDR_CTRL: begin
        rdata_d[CTRL_MODE] = mode_q;
`ifdef SMA_OUT_REPEAT_EN
        rdata_d[CTRL_REPEAT] = rep_q;
`endif
        rdata_d[CTRL_POL]  = pol_q;
        rdata_d[CTRL_BUSY] = busy;
      end
      ADDR_WIDTH: rdata_d[CNT_W-1:0] = width_q;
`ifdef SMA_OUT_REPEAT_EN
      ADDR_PERIOD: rdata_d[CNT_W-1:0] = period_q;
`endif
      default: rdata_d = '0;
    endcase
    out_d = pol_q ^ (mode_q ? (state == ST_HIGH) : data_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q   <= 1'b0;
      mode_q   <= 1'b0;
      pol_q    <= 1'b0;
      width_q  <= '0;
`ifdef SMA_OUT_REPEAT_EN
      rep_q    <= 1'b0;
      period_q <= '0;
`endif
      rdata_q  <= '0;
      out_q    <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      out_q   <= out_d;
      if (bus.write) begin
        case (bus.address)
          ADDR_DATA: data_q <= bus.writedata[0];
          ADDR_CTRL: begin
            mode_q <= bus.writedata[CTRL_MODE];
            pol_q  <= bus.writedata[CTRL_POL];
`ifdef SMA_OUT_REPEAT_EN
            rep_q  <= bus.writedata[CTRL_REPEAT];
`endif
          end
          ADDR_WIDTH: width_q <= bus.writedata[CNT_W-1:0];
`ifdef SMA_OUT_REPEAT_EN
          ADDR_PERIOD: period_q <= bus.writedata[CNT_W-1:0];
`endif
          default: ;
        endcase
      end
    end
  end

  assign bus.readdata = rdata_q;
  assign out_port     = out_q;

endmodule

// File: tb/tb_sma_out.sv
// Self-checking bench for sma_out: register vector table, directed pulse sequences,
// and randomized traffic against a cycle-level behavioural model.
module tb_sma_out;

  localparam int CNT_W = 16;
`ifdef SMA_OUT_REPEAT_EN
  localparam bit REP = 1'b1;
`else
  localparam bit REP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic out_port;

  sma_out_if bus ();

  sma_out #(.CNT_W(CNT_W)) dut (
    .clk      (clk),
    .reset    (reset),
    .bus      (bus),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [1:0]  a;
    logic        w;
    logic [31:0] d;
    logic [31:0] rd;
    logic        out;
  } vec_t;

  vec_t        tbl[12];
  logic [29:0] seq30;
  logic [14:0] seq15;
  logic [11:0] o12, b12;
  logic [7:0]  seq8;
  logic [5:0]  o6, b6;

  // Behavioural model: registers, phase (0 idle, 1 high, 2 low) and cycles left in it.
  bit          m_data, m_mode, m_rep, m_pol, m_out;
  int          m_width, m_period, m_phase, m_left;
  logic [31:0] m_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  // Inputs are driven at the falling edge; outputs are read at the next falling edge.
  task automatic tick(input logic [1:0] a, input logic w, input logic [31:0] d);
    bus.address   = a;
    bus.write     = w;
    bus.writedata = d;
    @(negedge clk);
    bus.write     = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2'd0, 1'b0, 32'd0);
    reset = 1'b0;
  endtask

  function automatic void model_step(input bit rst, input logic [1:0] a, input bit w,
                                     input logic [31:0] d);
    bit wc;
    if (rst) begin
      m_data = 0; m_mode = 0; m_rep = 0; m_pol = 0; m_out = 0;
      m_width = 0; m_period = 0; m_phase = 0; m_left = 0; m_rd = '0;
      return;
    end
    m_rd = '0;
    case (a)
      2'd0: m_rd[0] = m_data;
      2'd1: begin
        m_rd[0] = m_mode; m_rd[2] = m_rep; m_rd[3] = m_pol; m_rd[5] = (m_phase != 0);
      end
      2'd2: m_rd = 32'(m_width);
      default: m_rd = 32'(m_period);
    endcase
    m_out = m_pol ^ (m_mode ? (m_phase == 1) : m_data);
    wc = w && (a == 2'd1);
    if (wc && d[4]) m_phase = 0;
    else if (m_phase == 0) begin
      if (wc && d[1] && d[0] && m_width != 0) begin m_phase = 1; m_left = m_width; end
    end else if (m_phase == 1) begin
      m_left--;
      if (m_left == 0) begin
        if (m_rep) begin
          m_phase = 2;
          m_left  = (m_period > m_width) ? m_period - m_width : 1;
        end else m_phase = 0;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        if (m_rep && m_width != 0) begin m_phase = 1; m_left = m_width; end
        else m_phase = 0;
      end
    end
    if (w) begin
      case (a)
        2'd0: m_data = d[0];
        2'd1: begin m_mode = d[0]; m_rep = REP && d[2]; m_pol = d[3]; end
        2'd2: m_width = int'(d[15:0]);
        default: m_period = REP ? int'(d[15:0]) : 0;
      endcase
    end
  endfunction

  initial begin
    reset = 1'b1;
    bus.address = 2'd0; bus.write = 1'b0; bus.writedata = '0;
    @(negedge clk);

    // Reset state
    do_reset();
    check("reset out", 32'(out_port), 32'd0);
    check("reset rd", bus.readdata, 32'd0);

    // Register read/write table
    tbl[0]  = '{2'd0, 1'b1, 32'h0000_0001, 32'h0, 1'b0};
    tbl[1]  = '{2'd0, 1'b0, 32'h0,         32'h1, 1'b1};
    tbl[2]  = '{2'd2, 1'b1, 32'hFFFF_1234, 32'h0, 1'b1};
    tbl[3]  = '{2'd2, 1'b0, 32'h0,         32'h1234, 1'b1};
    tbl[4]  = '{2'd3, 1'b1, 32'hABCD_0005, 32'h0, 1'b1};
    tbl[5]  = '{2'd3, 1'b0, 32'h0,         REP ? 32'h5 : 32'h0, 1'b1};
    tbl[6]  = '{2'd1, 1'b1, 32'hFFFF_FFE8, 32'h0, 1'b1};
    tbl[7]  = '{2'd1, 1'b0, 32'h0,         32'h8, 1'b0};
    tbl[8]  = '{2'd0, 1'b1, 32'hFFFF_FFFE, 32'h1, 1'b0};
    tbl[9]  = '{2'd0, 1'b0, 32'h0,         32'h0, 1'b1};
    tbl[10] = '{2'd1, 1'b1, 32'h0000_0004, 32'h8, 1'b1};
    tbl[11] = '{2'd1, 1'b0, 32'h0,         REP ? 32'h4 : 32'h0, 1'b0};
    for (int i = 0; i < 12; i++) begin
      tick(tbl[i].a, tbl[i].w, tbl[i].d);
      check($sformatf("tbl%0d rd", i), bus.readdata, tbl[i].rd);
      check($sformatf("tbl%0d out", i), 32'(out_port), 32'(tbl[i].out));
    end

    // Single 5-cycle pulse with BUSY
    do_reset();
    tick(2'd2, 1'b1, 32'd5);
    tick(2'd1, 1'b1, 32'h03);
    for (int i = 0; i < 12; i++) begin
      tick(2'd1, 1'b0, 32'd0);
      o12[11-i] = out_port;
      b12[11-i] = bus.readdata[5];
    end
    check("pulse5 out", 32'(o12), 32'(12'b1111_1000_0000));
    check("pulse5 busy", 32'(b12), 32'(12'b1111_1000_0000));

    // Periodic 3/8, REPEAT cleared mid-HIGH of the third pulse
    do_reset();
    tick(2'd2, 1'b1, 32'd3);
    tick(2'd3, 1'b1, 32'd8);
    tick(2'd1, 1'b1, 32'h07);
    for (int i = 1; i <= 30; i++) begin
      if (i == 18) tick(2'd1, 1'b1, 32'h01);
      else         tick(2'd1, 1'b0, 32'd0);
      seq30[30-i] = out_port;
    end
    check("periodic out", 32'(seq30),
          REP ? 32'(30'b111000001110000011100000000000) : 32'(30'b111) << 27);
    tick(2'd3, 1'b0, 32'd0);
    check("period rd", bus.readdata, REP ? 32'd8 : 32'd0);
    tick(2'd1, 1'b0, 32'd0);
    check("ctrl rd idle", bus.readdata, 32'h01);

    // Inverted polarity: idle 1, active-low pulse of 4
    do_reset();
    tick(2'd2, 1'b1, 32'd4);
    tick(2'd1, 1'b1, 32'h09);
    tick(2'd1, 1'b0, 32'd0);
    check("pol idle", 32'(out_port), 32'd1);
    tick(2'd1, 1'b1, 32'h0B);
    for (int i = 0; i < 8; i++) begin
      tick(2'd1, 1'b0, 32'd0);
      seq8[7-i] = out_port;
    end
    check("pol pulse", 32'(seq8), 32'(8'b0000_1111));

    // ABORT together with START mid-pulse
    do_reset();
    tick(2'd2, 1'b1, 32'd3);
    tick(2'd3, 1'b1, 32'd6);
    tick(2'd1, 1'b1, 32'h07);
    for (int i = 0; i < 12; i++) begin
      if (i == 1) tick(2'd1, 1'b1, 32'h13);
      else        tick(2'd1, 1'b0, 32'd0);
      o12[11-i] = out_port;
      b12[11-i] = bus.readdata[5];
    end
    check("abort out", 32'(o12), 32'(12'b1100_0000_0000));
    check("abort busy", 32'(b12), 32'(12'b1100_0000_0000));
    check("abort ctrl", bus.readdata, 32'h01);

    // Reset mid-pulse, and reset with POL set
    do_reset();
    tick(2'd2, 1'b1, 32'd5);
    tick(2'd1, 1'b1, 32'h03);
    tick(2'd1, 1'b0, 32'd0);
    tick(2'd1, 1'b0, 32'd0);
    check("pre-reset out", 32'(out_port), 32'd1);
    reset = 1'b1; tick(2'd1, 1'b0, 32'd0); reset = 1'b0;
    check("rst mid out", 32'(out_port), 32'd0);
    check("rst mid rd", bus.readdata, 32'd0);
    tick(2'd1, 1'b1, 32'h08);
    tick(2'd1, 1'b0, 32'd0);
    check("pol static", 32'(out_port), 32'd1);
    reset = 1'b1; tick(2'd1, 1'b0, 32'd0); reset = 1'b0;
    check("rst pol out", 32'(out_port), 32'd0);
    tick(2'd1, 1'b0, 32'd0);
    check("rst ctrl rd", bus.readdata, 32'd0);

    // START with WIDTH=0, then WIDTH>PERIOD repeat
    do_reset();
    tick(2'd1, 1'b1, 32'h03);
    for (int i = 0; i < 6; i++) begin
      tick(2'd1, 1'b0, 32'd0);
      o6[5-i] = out_port;
      b6[5-i] = bus.readdata[5];
    end
    check("w0 out", 32'(o6), 32'd0);
    check("w0 busy", 32'(b6), 32'd0);
    tick(2'd2, 1'b1, 32'd4);
    tick(2'd3, 1'b1, 32'd2);
    tick(2'd1, 1'b1, 32'h07);
    for (int i = 0; i < 15; i++) begin
      tick(2'd1, 1'b0, 32'd0);
      seq15[14-i] = out_port;
    end
    check("w4p2 out", 32'(seq15),
          REP ? 32'(15'b111101111011110) : 32'(15'b111100000000000));

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      logic [1:0]  a;
      logic        w, r;
      logic [31:0] d;
      r = (i == 0) || ($urandom_range(0, 399) == 0);
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 5) == 0);
      d = $urandom;
      if (a == 2'd1) begin
        if ($urandom_range(0, 7) != 0) d[4] = 1'b0;
        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
      end else if (a == 2'd2) begin
        d = (d & 32'hFFFF_0000) | $urandom_range(0, 6);
      end else if (a == 2'd3) begin
        d = (d & 32'hFFFF_0000) | $urandom_range(0, 12);
      end
      model_step(r, a, w, d);
      reset = r;
      tick(a, w, d);
      reset = 1'b0;
      check($sformatf("rnd%0d out", i), 32'(out_port), 32'(m_out));
      check($sformatf("rnd%0d rd", i), bus.readdata, m_rd);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
